// File: rtl/ibex_fetch_pkg.sv
// rtl/ibex_fetch_pkg.sv - shared fetch-side types and helpers for the IF stage
package ibex_fetch_pkg;

    localparam int HALF_W = 16;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        is_compressed;
        logic        err;
    } fetch_instr_t;

    function automatic logic is_compressed(input logic [HALF_W-1:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/ibex_instr_aligner.sv
// rtl/ibex_instr_aligner.sv - splits/joins 32-bit fetch words into RV32IC instructions
module ibex_instr_aligner
    import ibex_fetch_pkg::*;
#(
    parameter bit ResetAll = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic [31:0] in_addr_i,
    input  logic        in_err_i,
    input  logic        in_err_plus2_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_is_compressed_o,
    output logic        out_err_o
);

    logic              hold_valid_q;
    logic [HALF_W-1:0] hold_half_q;
    logic [31:0]       hold_pc_q;
    logic              hold_err_q;

    logic [HALF_W-1:0] in_lo;
    logic [HALF_W-1:0] in_hi;
    fetch_instr_t      out_d;
    logic              out_valid;
    logic              in_ready;
    logic              hold_load;
    logic              hold_clear;
    logic [HALF_W-1:0] load_half;
    logic [31:0]       load_pc;
    logic              load_err;

    assign in_lo = in_rdata_i[15:0];
    assign in_hi = in_rdata_i[31:16];

    always_comb begin
        out_d      = '0;
        out_valid  = 1'b0;
        in_ready   = 1'b0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        load_half  = '0;
        load_pc    = '0;
        load_err   = 1'b0;
        if (flush_i) begin
            // Drain the stale head word and forget any residual half.
            in_ready   = 1'b1;
            hold_clear = 1'b1;
        end else if (hold_valid_q) begin
            if (is_compressed(hold_half_q) || hold_err_q) begin
                // An erroring hold never waits on the next word.
                out_d.instr         = {16'b0, hold_half_q};
                out_d.pc            = hold_pc_q;
                out_d.is_compressed = 1'b1;
                out_d.err           = hold_err_q;
                out_valid           = 1'b1;
                hold_clear          = out_ready_i;
            end else begin
                out_d.instr = {in_lo, hold_half_q};
                out_d.pc    = hold_pc_q;
                out_d.err   = hold_err_q | in_err_i | in_err_plus2_i;
                out_valid   = in_valid_i;
                if (in_valid_i && out_ready_i) begin
                    in_ready  = 1'b1;
                    hold_load = 1'b1;
                    load_half = in_hi;
                    load_pc   = hold_pc_q + 32'd4;
                    load_err  = in_err_i;
                end
            end
        end else if (!in_addr_i[1]) begin
            out_d.pc  = in_addr_i;
            out_d.err = in_err_i;
            out_valid = in_valid_i;
            if (is_compressed(in_lo)) begin
                out_d.instr         = {16'b0, in_lo};
                out_d.is_compressed = 1'b1;
                if (in_valid_i && out_ready_i) begin
                    in_ready  = 1'b1;
                    hold_load = 1'b1;
                    load_half = in_hi;
                    load_pc   = in_addr_i + 32'd2;
                    load_err  = in_err_i;
                end
            end else begin
                out_d.instr = in_rdata_i;
                in_ready    = in_valid_i && out_ready_i;
            end
        end else begin
            out_d.instr = {16'b0, in_hi};
            out_d.pc    = in_addr_i;
            out_d.err   = in_err_i;
            if (is_compressed(in_hi)) begin
                out_d.is_compressed = 1'b1;
                out_valid           = in_valid_i;
                in_ready            = in_valid_i && out_ready_i;
            end else begin
                // Upper half starts a 32-bit instruction: park it, fetch the rest.
                in_ready  = 1'b1;
                hold_load = in_valid_i;
                load_half = in_hi;
                load_pc   = in_addr_i;
                load_err  = in_err_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_err_q   <= 1'b0;
        end else if (hold_load) begin
            hold_valid_q <= 1'b1;
            hold_err_q   <= load_err;
        end else if (hold_clear) begin
            hold_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni && ResetAll) begin
            hold_half_q <= '0;
            hold_pc_q   <= '0;
        end else if (rst_ni && hold_load) begin
            hold_half_q <= load_half;
            hold_pc_q   <= load_pc;
        end
    end

    assign out_valid_o         = rst_ni & out_valid;
    assign in_ready_o          = rst_ni & in_ready;
    assign out_instr_o         = out_d.instr;
    assign out_pc_o            = out_d.pc;
    assign out_is_compressed_o = out_d.is_compressed;
    assign out_err_o           = out_d.err;

endmodule

// File: tb/tb_ibex_instr_aligner.sv
// tb/tb_ibex_instr_aligner.sv - directed self-checking bench for ibex_instr_aligner
module tb_ibex_instr_aligner;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_rdata_i = '0;
    logic [31:0] in_addr_i = '0;
    logic        in_err_i = 1'b0;
    logic        in_err_plus2_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_is_compressed_o;
    logic        out_err_o;

    int checks = 0;
    int errors = 0;
    logic [67:0] obs;
    logic [67:0] exp_v;
    logic [1:0]  hs;

    ibex_instr_aligner dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_rdata_i(in_rdata_i),
        .in_addr_i(in_addr_i), .in_err_i(in_err_i), .in_err_plus2_i(in_err_plus2_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o),
        .out_pc_o(out_pc_o), .out_is_compressed_o(out_is_compressed_o), .out_err_o(out_err_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs = {out_valid_o, in_ready_o, out_is_compressed_o, out_err_o, out_instr_o, out_pc_o};
    assign hs  = {out_valid_o, in_ready_o};

    function automatic logic [67:0] ex(input logic v, input logic r, input logic c, input logic e,
                                       input logic [31:0] instr, input logic [31:0] pc);
        return {v, r, c, e, instr, pc};
    endfunction

    task automatic drive(input logic rst, input logic fl, input logic rdy, input logic v,
                         input logic [31:0] d, input logic [31:0] a, input logic e, input logic p2);
        @(negedge clk_i);
        rst_ni = rst; flush_i = fl; out_ready_i = rdy; in_valid_i = v;
        in_rdata_i = d; in_addr_i = a; in_err_i = e; in_err_plus2_i = p2;
        #1;
    endtask

    task automatic test_reset;
        drive(0, 0, 1, 1, 32'h0000_0013, 32'h80, 0, 0);
        checks++; if (hs !== 2'b00) begin errors++; $display("FAIL reset_gate: got %b exp 00", hs); end
        drive(1, 0, 1, 0, 32'h0, 32'h0, 0, 0);
        checks++; if (hs !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b exp 00", hs); end
    endtask

    task automatic test_aligned;
        drive(1, 0, 1, 1, 32'h0000_0013, 32'h80, 0, 0);
        exp_v = ex(1, 1, 0, 0, 32'h0000_0013, 32'h80);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL aligned_0: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 1, 32'h0000_0093, 32'h84, 0, 0);
        exp_v = ex(1, 1, 0, 0, 32'h0000_0093, 32'h84);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL aligned_1: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 0, 32'h0, 32'h0, 0, 0);
        checks++; if (hs !== 2'b00) begin errors++; $display("FAIL aligned_idle: got %b exp 00", hs); end
    endtask

    task automatic test_compressed_pair;
        drive(1, 0, 1, 1, 32'h4501_4501, 32'h80, 0, 0);
        exp_v = ex(1, 1, 1, 0, 32'h0000_4501, 32'h80);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL cpair_lo: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 1, 32'h0000_0013, 32'h84, 0, 0);
        exp_v = ex(1, 0, 1, 0, 32'h0000_4501, 32'h82);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL cpair_hold: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 1, 32'h0000_0013, 32'h84, 0, 0);
        exp_v = ex(1, 1, 0, 0, 32'h0000_0013, 32'h84);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL cpair_next: got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_straddle;
        drive(1, 0, 1, 1, 32'h0013_4501, 32'h80, 0, 0);
        exp_v = ex(1, 1, 1, 0, 32'h0000_4501, 32'h80);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL strad_c: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 1, 32'hAAAA_0000, 32'h84, 0, 0);
        exp_v = ex(1, 1, 0, 0, 32'h0000_0013, 32'h82);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL strad_join: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 0, 32'h0, 32'h0, 0, 0);
        exp_v = ex(1, 0, 1, 0, 32'h0000_AAAA, 32'h86);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL strad_tail: got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_branch_target;
        drive(1, 0, 1, 1, 32'h0093_1234, 32'h102, 0, 0);
        checks++; if (hs !== 2'b01) begin errors++; $display("FAIL br_park: got %b exp 01", hs); end
        drive(1, 0, 1, 1, 32'h0000_0000, 32'h104, 0, 0);
        exp_v = ex(1, 1, 0, 0, 32'h0000_0093, 32'h102);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL br_join: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 0, 32'h0, 32'h0, 0, 0);
        exp_v = ex(1, 0, 1, 0, 32'h0000_0000, 32'h106);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL br_tail: got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_errors;
        drive(1, 0, 1, 1, 32'h0013_4501, 32'h80, 0, 0);
        drive(1, 0, 1, 1, 32'h0013_0000, 32'h84, 1, 0);
        exp_v = ex(1, 1, 0, 1, 32'h0000_0013, 32'h82);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL err_join: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 0, 32'h0, 32'h0, 0, 0);
        exp_v = ex(1, 0, 1, 1, 32'h0000_0013, 32'h86);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL err_hold_bypass: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 1, 32'h0013_4501, 32'h80, 0, 0);
        drive(1, 0, 1, 1, 32'hAAAA_0000, 32'h84, 0, 1);
        exp_v = ex(1, 1, 0, 1, 32'h0000_0013, 32'h82);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL err_plus2: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 0, 32'h0, 32'h0, 0, 0);
        exp_v = ex(1, 0, 1, 0, 32'h0000_AAAA, 32'h86);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL err_plus2_tail: got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_flush_stall;
        drive(1, 0, 1, 1, 32'h4501_4501, 32'h80, 0, 0);
        drive(1, 0, 0, 1, 32'h0000_0013, 32'h84, 0, 0);
        exp_v = ex(1, 0, 1, 0, 32'h0000_4501, 32'h82);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL stall_0: got %h exp %h", obs, exp_v); end
        drive(1, 0, 0, 1, 32'h0000_0013, 32'h84, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL stall_1: got %h exp %h", obs, exp_v); end
        drive(1, 1, 0, 1, 32'h0000_0013, 32'h84, 0, 0);
        checks++; if (hs !== 2'b01) begin errors++; $display("FAIL flush_same: got %b exp 01", hs); end
        drive(1, 0, 1, 1, 32'h0000_0093, 32'h200, 0, 0);
        exp_v = ex(1, 1, 0, 0, 32'h0000_0093, 32'h200);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL flush_next: got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_hold;
        drive(1, 0, 1, 1, 32'h4501_4501, 32'h80, 0, 0);
        drive(0, 0, 1, 0, 32'h0, 32'h0, 0, 0);
        checks++; if (hs !== 2'b00) begin errors++; $display("FAIL rst_mid_gate: got %b exp 00", hs); end
        drive(1, 0, 1, 0, 32'h0, 32'h0, 0, 0);
        checks++; if (hs !== 2'b00) begin errors++; $display("FAIL rst_mid_after: got %b exp 00", hs); end
        drive(1, 0, 1, 1, 32'h0000_0013, 32'h300, 0, 0);
        exp_v = ex(1, 1, 0, 0, 32'h0000_0013, 32'h300);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL rst_mid_new: got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_pc_wrap;
        drive(1, 0, 1, 1, 32'h0013_4501, 32'hFFFF_FFFC, 0, 0);
        exp_v = ex(1, 1, 1, 0, 32'h0000_4501, 32'hFFFF_FFFC);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL wrap_c: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 1, 32'hAAAA_0000, 32'h0, 0, 0);
        exp_v = ex(1, 1, 0, 0, 32'h0000_0013, 32'hFFFF_FFFE);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL wrap_join: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 0, 32'h0, 32'h0, 0, 0);
        exp_v = ex(1, 0, 1, 0, 32'h0000_AAAA, 32'h0000_0002);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL wrap_tail: got %h exp %h", obs, exp_v); end
        drive(1, 0, 1, 0, 32'h0, 32'h0, 0, 0);
    endtask

    initial begin
        test_reset;
        test_aligned;
        test_compressed_pair;
        test_straddle;
        test_branch_target;
        test_errors;
        test_flush_stall;
        test_reset_mid_hold;
        test_pc_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
